// File: rtl/mst_mdl_if.sv
// simple_if: single-master bus carrying address, write request/data, read request and registered read return.
//   addr, wr_req, wr_data, rd_req : driven by the master
//   rd_data_vld, rd_data          : driven by the slave
interface simple_if #(
  parameter int ADDR_BIT_WIDTH = 2,
  parameter int DATA_BIT_WIDTH = 8
);
  logic [ADDR_BIT_WIDTH-1:0] addr;
  logic                      wr_req;
  logic [DATA_BIT_WIDTH-1:0] wr_data;
  logic                      rd_req;
  logic                      rd_data_vld;
  logic [DATA_BIT_WIDTH-1:0] rd_data;
  modport mst_port (output addr, wr_req, wr_data, rd_req, input rd_data_vld, rd_data);
  modport slv_port (input addr, wr_req, wr_data, rd_req, output rd_data_vld, rd_data);
endinterface

// File: rtl/mst_mdl.sv
// mst_mdl: simple_if bus master turning single user read/write commands into bus cycles.
//   i_clk, i_sync_rst            : clock, synchronous active-high reset
//   i_cmd_* / o_cmd_rdy          : command port (valid/ready), accepted only in IDLE
//   o_rsp_* / i_rsp_rdy          : response port (valid/ready), read data or timeout flag
//   o_busy                       : state is not IDLE
//   if_bus                       : simple_if master side
//   MST_MDL_WR_RSP_EN            : when defined, writes also return a (zero) response
module mst_mdl #(
  parameter int ADDR_BIT_WIDTH = 2,
  parameter int DATA_BIT_WIDTH = 8,
  parameter int TIMEOUT_CYC    = 16
) (
  input  logic                      i_clk,
  input  logic                      i_sync_rst,
  input  logic                      i_cmd_vld,
  output logic                      o_cmd_rdy,
  input  logic                      i_cmd_wr,
  input  logic [ADDR_BIT_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_BIT_WIDTH-1:0] i_cmd_wr_data,
  output logic                      o_rsp_vld,
  input  logic                      i_rsp_rdy,
  output logic [DATA_BIT_WIDTH-1:0] o_rsp_rd_data,
  output logic                      o_rsp_timeout,
  output logic                      o_busy,
  simple_if.mst_port                if_bus
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;
  state_t                    state_q;
  logic [ADDR_BIT_WIDTH-1:0] addr_q;
  logic [DATA_BIT_WIDTH-1:0] wr_data_q;
  logic [DATA_BIT_WIDTH-1:0] rd_data_q;
  logic                      timeout_q;
  logic [CW-1:0]             cnt_q;
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_cmd_vld) begin
          addr_q    <= i_cmd_addr;
          wr_data_q <= i_cmd_wr_data;
          state_q   <= i_cmd_wr ? WR : RD;
        end
`ifdef MST_MDL_WR_RSP_EN
        WR: begin
          rd_data_q <= '0;
          timeout_q <= 1'b0;
          state_q   <= RSP;
        end
`else
        WR: state_q <= IDLE;
`endif
        // valid data has priority over an expiring counter in the same cycle
        RD: if (if_bus.rd_data_vld) begin
          rd_data_q <= if_bus.rd_data;
          timeout_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= RSP;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          rd_data_q <= '0;
          timeout_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= RSP;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        RSP: if (i_rsp_rdy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign o_cmd_rdy      = state_q == IDLE;
  assign o_busy         = state_q != IDLE;
  assign o_rsp_vld      = state_q == RSP;
  assign o_rsp_rd_data  = rd_data_q;
  assign o_rsp_timeout  = timeout_q;
  assign if_bus.addr    = addr_q;
  assign if_bus.wr_data = wr_data_q;
  assign if_bus.wr_req  = state_q == WR;
  assign if_bus.rd_req  = state_q == RD;
endmodule

// File: tb/tb_mst_mdl.sv
// tb_mst_mdl: self-checking bench for mst_mdl with a registered zero-wait memory slave.
module tb_mst_mdl;
  localparam int TO = 16;
`ifdef MST_MDL_WR_RSP_EN
  localparam int WR_GAP = 3;
`else
  localparam int WR_GAP = 2;
`endif
  logic clk = 0, rst = 1;
  logic cmd_vld = 0, cmd_wr = 0, rsp_rdy = 1, stub = 0;
  logic [1:0] cmd_addr = 0;
  logic [7:0] cmd_wr_data = 0;
  logic o_cmd_rdy, o_rsp_vld, o_rsp_timeout, o_busy;
  logic [7:0] o_rsp_rd_data;
  logic [7:0] mem [4];
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {logic wr; logic [1:0] a; logic [7:0] d; logic [7:0] ed;} vec_t;
  typedef struct {logic [7:0] d; logic to; int lat; int acc;} exp_t;
  exp_t q[$];
  vec_t tbl[10];
  simple_if #(.ADDR_BIT_WIDTH(2), .DATA_BIT_WIDTH(8)) bus ();
  mst_mdl #(.ADDR_BIT_WIDTH(2), .DATA_BIT_WIDTH(8), .TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_sync_rst(rst), .i_cmd_vld(cmd_vld), .o_cmd_rdy(o_cmd_rdy),
    .i_cmd_wr(cmd_wr), .i_cmd_addr(cmd_addr), .i_cmd_wr_data(cmd_wr_data),
    .o_rsp_vld(o_rsp_vld), .i_rsp_rdy(rsp_rdy), .o_rsp_rd_data(o_rsp_rd_data),
    .o_rsp_timeout(o_rsp_timeout), .o_busy(o_busy), .if_bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (bus.wr_req) mem[bus.addr] <= bus.wr_data;
    bus.rd_data_vld <= bus.rd_req && !stub;
    bus.rd_data     <= mem[bus.addr];
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask
  task automatic expect_rsp(input logic [7:0] d, input logic to, input int lat);
    q.push_back('{d: d, to: to, lat: lat, acc: cyc});
  endtask
  task automatic monitor();
    exp_t e;
    bit pv = 0;
    forever begin
      @(negedge clk);
      if (o_rsp_vld && !pv) begin
        if (q.size() == 0) chk("unexpected_rsp", o_rsp_vld, 0);
        else chk("rsp_latency", cyc - q[0].acc, q[0].lat);
      end
      if (o_rsp_vld && rsp_rdy && q.size() > 0) begin
        e = q.pop_front();
        chk("rsp_data", o_rsp_rd_data, e.d);
        chk("rsp_timeout", o_rsp_timeout, e.to);
      end
      pv = o_rsp_vld;
    end
  endtask
  task automatic issue(input logic wr, input logic [1:0] a, input logic [7:0] d);
    int n = 0;
    while (!o_cmd_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_cmd_rdy) begin
      chk("cmd_rdy_wait", o_cmd_rdy, 1);
      return;
    end
    cmd_vld = 1; cmd_wr = wr; cmd_addr = a; cmd_wr_data = d;
    @(posedge clk); #1;
    cmd_vld = 0;
    chk("cmd_rdy_low_busy", o_cmd_rdy, 0);
    chk("bus_addr", bus.addr, a);
    if (wr) chk("bus_wr_data", bus.wr_data, d);
    chk(wr ? "wr_req_on" : "rd_req_on", wr ? bus.wr_req : bus.rd_req, 1);
    chk("req_exclusive", bus.wr_req & bus.rd_req, 0);
  endtask
  task automatic wait_vld();
    int n = 0;
    while (!o_rsp_vld && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_vld_wait", o_rsp_vld, 1);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", q.size(), 0);
  endtask
  initial begin
    int last = 0, n;
    tbl = '{'{1, 2, 8'hA5, 0}, '{0, 2, 0, 8'hA5},
            '{1, 0, 8'h11, 0}, '{1, 1, 8'h22, 0}, '{1, 2, 8'h33, 0}, '{1, 3, 8'h44, 0},
            '{0, 3, 0, 8'h44}, '{0, 0, 0, 8'h11}, '{0, 1, 0, 8'h22}, '{0, 2, 0, 8'h33}};
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_rdy", o_cmd_rdy, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_rsp_vld", o_rsp_vld, 0);
    chk("rst_reqs", {bus.wr_req, bus.rd_req}, 0);
    chk("rst_addr_wdata", {bus.addr, bus.wr_data}, 0);
    chk("rst_rsp_data_to", {o_rsp_rd_data, o_rsp_timeout}, 0);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].wr, tbl[i].a, tbl[i].d);
      if (i > 0 && tbl[i].wr == tbl[i-1].wr) chk("cmd_spacing", cyc - last, tbl[i].wr ? WR_GAP : 4);
      last = cyc;
      if (tbl[i].wr) begin
`ifdef MST_MDL_WR_RSP_EN
        expect_rsp(8'h00, 1'b0, 1);
`endif
        @(posedge clk); #1;
        chk("wr_req_one_cycle", bus.wr_req, 0);
      end else expect_rsp(tbl[i].ed, 1'b0, 2);
    end
    drain();
    stub = 1;
    issue(0, 0, 0);
    expect_rsp(8'h00, 1'b1, TO);
    n = 0;
    while (bus.rd_req && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    chk("rd_req_timeout_cycles", n, TO);
    stub = 0;
    drain();
    rsp_rdy = 0;
    issue(0, 1, 0);
    expect_rsp(8'h22, 1'b0, 2);
    wait_vld();
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_vld", o_rsp_vld, 1);
      chk("hold_rsp_data", {o_rsp_rd_data, o_rsp_timeout}, {8'h22, 1'b0});
      chk("hold_cmd_rdy", o_cmd_rdy, 0);
      chk("hold_no_bus", {bus.wr_req, bus.rd_req}, 0);
      @(posedge clk); #1;
    end
    rsp_rdy = 1;
    drain();
    issue(0, 2, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_rd_req", bus.rd_req, 0);
    chk("midrst_rsp_vld", o_rsp_vld, 0);
    chk("midrst_idle", {o_cmd_rdy, o_busy}, 2'b10);
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_no_rsp", o_rsp_vld, 0);
    issue(0, 3, 0);
    expect_rsp(8'h44, 1'b0, 2);
    drain();
`ifdef MST_MDL_WR_RSP_EN
    rsp_rdy = 0;
    issue(1, 0, 8'h5A);
    expect_rsp(8'h00, 1'b0, 1);
    wait_vld();
    repeat (3) begin
      chk("wrsp_hold", {o_rsp_vld, o_rsp_rd_data, o_rsp_timeout}, {1'b1, 8'h00, 1'b0});
      @(posedge clk); #1;
    end
    rsp_rdy = 1;
    drain();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
